fpf_grant_scheduler: RTL and testbench

- Sequential arbiter sharing one resource (output slot/target) among N requesters, each tagged with one of P priority levels.
- Priority vector uses the framework's flattened layout: bit j*N+i = requester i active at priority j. It can be fed directly from the mask stage's per-priority result vector.
- Picks the highest active level; round-robin within that level. Holds the grant until release, then rotates.

---
 rtl/fpf_grant_scheduler.sv | 154 +++++++++++++++
 tb/tb_fpf_grant_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpf_grant_scheduler.sv
// Priority-then-round-robin grant scheduler: one holder at a time, no preemption.
// Define FPF_GRANT_TIMEOUT_EN to revoke grants held for TIMEOUT cycles.
module fpf_grant_scheduler #(
    parameter int unsigned N       = 24,
    parameter int unsigned P       = 8,
    parameter int unsigned NW      = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned PW      = (P > 1) ? $clog2(P) : 1,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic [N*P-1:0]  i_req_pri,
    input  logic            i_release,
    output logic [N-1:0]    o_gnt,
    output logic            o_gnt_vld,
    output logic [NW-1:0]   o_gnt_id,
    output logic [PW-1:0]   o_gnt_pri,
    output logic            o_timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [NW-1:0] id_q, id_d;
    logic [PW-1:0] pri_q, pri_d;
    logic [NW-1:0] ptr_q [P];
    logic [NW-1:0] ptr_d [P];

`ifdef FPF_GRANT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic [PW-1:0] lvl [N];
    logic [PW-1:0] win_lvl;
    logic [N-1:0]  cand;
    logic [NW-1:0] win_id;
    logic [NW-1:0] scan_idx;
    logic [NW:0]   scan_sum;
    logic          found;

    // Winner level, candidate set, then a rotating scan starting at that level's pointer.
    always_comb begin
        win_lvl  = '0;
        cand     = '0;
        win_id   = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            lvl[i] = '0;
            for (int j = 0; j < P; j++) begin
                if (i_req_pri[j*N+i]) lvl[i] = PW'(j);
            end
            if (i_req[i] && (lvl[i] > win_lvl)) win_lvl = lvl[i];
        end
        for (int i = 0; i < N; i++) begin
            cand[i] = i_req[i] && (lvl[i] == win_lvl);
        end
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, ptr_q[win_lvl]} + (NW+1)'(k);
            if (scan_sum >= (NW+1)'(N)) scan_sum = scan_sum - (NW+1)'(N);
            scan_idx = scan_sum[NW-1:0];
            if (!found && cand[scan_idx]) begin
                found  = 1'b1;
                win_id = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        pri_d   = pri_q;
        ptr_d   = ptr_q;
`ifdef FPF_GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d         = StGrant;
                    gnt_d           = '0;
                    gnt_d[win_id]   = 1'b1;
                    id_d            = win_id;
                    pri_d           = win_lvl;
                    ptr_d[win_lvl]  = (win_id == NW'(N - 1)) ? '0 : win_id + NW'(1);
`ifdef FPF_GRANT_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            StGrant: begin
                if (i_release || !i_req[id_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    id_d    = '0;
                    pri_d   = '0;
`ifdef FPF_GRANT_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    id_d      = '0;
                    pri_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            id_q    <= '0;
            pri_q   <= '0;
            for (int l = 0; l < P; l++) ptr_q[l] <= '0;
`ifdef FPF_GRANT_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            pri_q   <= pri_d;
            for (int l = 0; l < P; l++) ptr_q[l] <= ptr_d[l];
`ifdef FPF_GRANT_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = (state_q == StGrant);
    assign o_gnt_id  = id_q;
    assign o_gnt_pri = pri_q;
`ifdef FPF_GRANT_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpf_grant_scheduler.sv
// Scoreboard bench for fpf_grant_scheduler (N=4, P=4, TIMEOUT=8).
module tb_fpf_grant_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_pri;
    logic        rel;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic [1:0]  gnt_pri;
    logic        timeout;
    logic        done;

    typedef struct packed {
        logic       vld;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [1:0] pri;
        logic       to;
    } probe_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] pri;
    } grant_t;

    probe_t probe_q [$];
    grant_t grant_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cycles  = 0;
    logic prev_vld = 1'b0;

    fpf_grant_scheduler #(
        .N       (4),
        .P       (4),
        .NW      (2),
        .PW      (2),
        .TIMEOUT (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_req_pri (req_pri),
        .i_release (rel),
        .o_gnt     (gnt),
        .o_gnt_vld (gnt_vld),
        .o_gnt_id  (gnt_id),
        .o_gnt_pri (gnt_pri),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every comparison and the summary live here.
    always @(negedge clk) begin
        probe_t p;
        grant_t g;
        logic [3:0] exp_oh;
        cycles++;
        if (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            n_tests++;
            if ({gnt_vld, gnt, gnt_id, gnt_pri, timeout} !== p) begin
                n_fail++;
                $display("FAIL probe@%0t: got vld=%0b gnt=%b id=%0d pri=%0d to=%0b, want vld=%0b gnt=%b id=%0d pri=%0d to=%0b",
                         $time, gnt_vld, gnt, gnt_id, gnt_pri, timeout,
                         p.vld, p.gnt, p.id, p.pri, p.to);
            end
        end
        if (gnt_vld && !prev_vld) begin
            n_tests++;
            if (grant_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_order@%0t: got unexpected grant id=%0d pri=%0d, want none",
                         $time, gnt_id, gnt_pri);
            end else begin
                g = grant_q.pop_front();
                exp_oh = 4'b0001 << g.id;
                if (gnt !== exp_oh || gnt_id !== g.id || gnt_pri !== g.pri) begin
                    n_fail++;
                    $display("FAIL grant_order@%0t: got gnt=%b id=%0d pri=%0d, want gnt=%b id=%0d pri=%0d",
                             $time, gnt, gnt_id, gnt_pri, exp_oh, g.id, g.pri);
                end
            end
        end
        prev_vld = gnt_vld;
        if (done || cycles > 2000) begin
            if (!done) begin
                n_tests++;
                n_fail++;
                $display("FAIL watchdog: got %0d cycles, want stimulus done", cycles);
            end
            n_tests++;
            if (grant_q.size() != 0 || probe_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d grants %0d probes pending, want 0 0",
                         grant_q.size(), probe_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_probe(input logic v, input logic [3:0] g, input logic [1:0] id,
                              input logic [1:0] pri, input logic to);
        probe_t p;
        p.vld = v;
        p.gnt = g;
        p.id  = id;
        p.pri = pri;
        p.to  = to;
        probe_q.push_back(p);
    endtask

    task automatic expect_grant(input logic [1:0] id, input logic [1:0] pri);
        grant_t g;
        g.id  = id;
        g.pri = pri;
        grant_q.push_back(g);
    endtask

    task automatic step_idle();
        cyc();
        push_probe(1'b0, 4'b0000, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic step_grant(input logic [3:0] g, input logic [1:0] id, input logic [1:0] pri);
        cyc();
        push_probe(1'b1, g, id, pri, 1'b0);
    endtask

    task automatic release_grant(input logic [3:0] new_req);
        rel = 1'b1;
        req = new_req;
        step_idle();
        rel = 1'b0;
    endtask

    initial begin
        logic [3:0] oh;
        rst_n   = 1'b0;
        req     = '0;
        req_pri = '0;
        rel     = 1'b0;
        done    = 1'b0;
        step_idle();
        step_idle();
        #2 rst_n = 1'b1;

        // Mixed levels; release asserted in IDLE must be ignored.
        req     = 4'b0101;
        req_pri = 16'h4010;
        rel     = 1'b1;
        expect_grant(2'd2, 2'd3);
        step_grant(4'b0100, 2'd2, 2'd3);
        rel = 1'b0;
        step_grant(4'b0100, 2'd2, 2'd3);
        release_grant(4'b0001);
        expect_grant(2'd0, 2'd1);
        step_grant(4'b0001, 2'd0, 2'd1);
        release_grant(4'b0000);
        // ptr[3] is now 3, so req3 wins over req2 at level 3.
        req     = 4'b1100;
        req_pri = 16'hC000;
        expect_grant(2'd3, 2'd3);
        step_grant(4'b1000, 2'd3, 2'd3);
        release_grant(4'b0000);

        // Round-robin at level 2 with one idle cycle between grants.
        req     = 4'b1111;
        req_pri = 16'h0F00;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            expect_grant(2'(k % 4), 2'd2);
            step_grant(oh, 2'(k % 4), 2'd2);
            release_grant((k == 4) ? 4'b0000 : 4'b1111);
        end

        // No preemption by a higher-level request.
        req     = 4'b0010;
        req_pri = 16'h0000;
        expect_grant(2'd1, 2'd0);
        step_grant(4'b0010, 2'd1, 2'd0);
        req     = 4'b1010;
        req_pri = 16'h8000;
        repeat (3) step_grant(4'b0010, 2'd1, 2'd0);
        release_grant(4'b1010);
        expect_grant(2'd3, 2'd3);
        step_grant(4'b1000, 2'd3, 2'd3);

        // Holder drops its request without release.
        req = 4'b0010;
        step_idle();
        expect_grant(2'd1, 2'd0);
        step_grant(4'b0010, 2'd1, 2'd0);

        // Asynchronous reset mid-grant; ptr[2] (was 1) must restart at 0.
        cyc();
        #1 rst_n = 1'b0;
        push_probe(1'b0, 4'b0000, 2'd0, 2'd0, 1'b0);
        cyc();
        #3 rst_n = 1'b1;
        push_probe(1'b0, 4'b0000, 2'd0, 2'd0, 1'b0);
        req     = 4'b1111;
        req_pri = 16'h0F00;
        expect_grant(2'd0, 2'd2);
        step_grant(4'b0001, 2'd0, 2'd2);
        release_grant(4'b0000);

        // Long hold without release.
        req     = 4'b0011;
        req_pri = 16'h0000;
        expect_grant(2'd0, 2'd0);
        repeat (8) step_grant(4'b0001, 2'd0, 2'd0);
`ifdef FPF_GRANT_TIMEOUT_EN
        cyc();
        push_probe(1'b0, 4'b0000, 2'd0, 2'd0, 1'b1);
        expect_grant(2'd1, 2'd0);
        step_grant(4'b0010, 2'd1, 2'd0);
        release_grant(4'b0000);
`else
        repeat (2) step_grant(4'b0001, 2'd0, 2'd0);
        release_grant(4'b0000);
`endif
        step_idle();
        cyc();
        done = 1'b1;
    end

endmodule
